mem_port_arbiter: RTL

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 103 ++++++++++
 2 files changed

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch, data and memory port signals of mem_port_arbiter.
//   slave  : arbiter side (takes requests and mem_rdata, drives grants,
//            responses, the memory issue bus and stall)
//   master : requester/memory-model side (mirror image of slave)
interface mem_port_arbiter_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // fetch port
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic                  if_ready;
    logic                  if_rvalid;
    logic [DATA_WIDTH-1:0] if_rdata;
    // data port
    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [DATA_WIDTH-1:0] d_wdata;
    logic [2:0]            d_size;
    logic                  d_ready;
    logic                  d_rvalid;
    logic [DATA_WIDTH-1:0] d_rdata;
    // memory port
    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [2:0]            mem_size;
    logic [DATA_WIDTH-1:0] mem_rdata;
    // pipeline back-pressure
    logic                  stall;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata,
        output if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_size, stall
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_size, mem_rdata,
        input  if_ready, if_rvalid, if_rdata, d_ready, d_rvalid, d_rdata,
               mem_en, mem_we, mem_addr, mem_wdata, mem_size, stall
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-way arbiter sharing one single-issue memory port between instruction
// fetch and load/store. Grants are combinational in any grant window; a
// read blocks further grants until its data returns MEM_LATENCY cycles
// later, and a new grant may overlap that return cycle.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset; forces every output to 0
//   bus  - mem_port_arbiter_if.slave: fetch port, data port, memory port, stall
module mem_port_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_LATENCY = 2,   // 1..7
    parameter int MAX_STREAK  = 3
) (
    input  logic                clk,
    input  logic                rst,
    mem_port_arbiter_if.slave   bus
);
    localparam int              SW   = (MAX_STREAK < 1) ? 1 : $clog2(MAX_STREAK + 1);
    localparam logic [2:0]      LAT  = 3'(MEM_LATENCY);
    localparam logic [SW-1:0]   SMAX = SW'(MAX_STREAK);

    typedef enum logic {IDLE, WAIT_RD} state_t;

    state_t        r_state, w_state_nxt;
    logic [2:0]    r_cnt, w_cnt_nxt;        // read countdown, 1 = data returns now
    logic [SW-1:0] r_streak, w_streak_nxt;  // consecutive contested data wins
    logic          r_owner, w_owner_nxt;    // 0 = fetch, 1 = data

    logic w_win, w_fetch_pri, w_gnt_f, w_gnt_d, w_rd_gnt, w_ret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_streak <= '0;
            r_owner  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_streak <= w_streak_nxt;
            r_owner  <= w_owner_nxt;
        end
    end

    always_comb begin
        // The return cycle of an outstanding read doubles as a grant window.
        // rst gates everything so outputs are 0 independent of the clock.
        w_win       = !rst && (r_state == IDLE || r_cnt == 3'd1);
        w_ret       = !rst && (r_cnt == 3'd1);
        w_fetch_pri = (r_streak == SMAX) && bus.if_req && bus.d_req;
        w_gnt_d     = w_win && bus.d_req && !w_fetch_pri;
        w_gnt_f     = w_win && bus.if_req && !w_gnt_d;
        w_rd_gnt    = w_gnt_f || (w_gnt_d && !bus.d_we);

        w_state_nxt  = r_state;
        w_cnt_nxt    = (r_cnt != 3'd0) ? r_cnt - 3'd1 : 3'd0;
        w_streak_nxt = r_streak;
        w_owner_nxt  = r_owner;

        if (w_win)
            w_state_nxt = IDLE;
        if (w_rd_gnt) begin
            w_cnt_nxt   = LAT;
            w_owner_nxt = w_gnt_d;
            // With single-cycle latency the return cycle is already a window.
            w_state_nxt = (LAT > 3'd1) ? WAIT_RD : IDLE;
        end

        if (w_gnt_f)
            w_streak_nxt = '0;
        else if (w_gnt_d && bus.if_req && r_streak != SMAX)
            w_streak_nxt = r_streak + 1'b1;
    end

    always_comb begin
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_size  = 3'b000;
        if (w_gnt_d) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            bus.mem_size  = bus.d_size;
        end else if (w_gnt_f) begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.if_addr;
            bus.mem_size  = 3'b010;
        end
    end

    assign bus.if_ready  = w_gnt_f;
    assign bus.d_ready   = w_gnt_d;
    assign bus.if_rvalid = w_ret && !r_owner;
    assign bus.d_rvalid  = w_ret && r_owner;
    assign bus.if_rdata  = rst ? '0 : bus.mem_rdata;
    assign bus.d_rdata   = rst ? '0 : bus.mem_rdata;
    assign bus.stall     = !rst && ((bus.if_req && !w_gnt_f) || (bus.d_req && !w_gnt_d));

endmodule
